fir_mac_sequencer: RTL

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR MAC: loads coefficients, accepts one sample,
// walks the taps through the MAC, drains the multiplier stage and hands off the result.
module fir_mac_sequencer #(
  parameter int unsigned NTAPS = 64
) (
  input  logic       clk1,
  input  logic       ALU_restn,
  input  logic       coef_valid,
  output logic       coef_ready,
  output logic       coef_we,
  output logic [5:0] coef_addr,
  input  logic       x_valid,
  output logic       x_ready,
  output logic       x_shift,
  output logic [5:0] tap_addr,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       y_valid,
  input  logic       y_ready,
  input  logic       cfg_reload,
  output logic       busy
);

  localparam logic [2:0] StLoad  = 3'd0;
  localparam logic [2:0] StWaitX = 3'd1;
  localparam logic [2:0] StMac   = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;

  localparam logic [5:0] LastTap = 6'(NTAPS - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       coef_hs;
  logic       x_hs;

  assign coef_hs = (state_q == StLoad) && coef_valid;
  // A reload request in the same cycle as a sample takes priority over the sample.
  assign x_hs    = (state_q == StWaitX) && x_valid && !cfg_reload;

  // One counter serves as load index in LOAD and tap index in MAC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StLoad: begin
        if (coef_hs) begin
          if (cnt_q == LastTap) begin
            cnt_d   = 6'd0;
            state_d = StWaitX;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StWaitX: begin
        cnt_d = 6'd0;
        if (cfg_reload) begin
          state_d = StLoad;
        end else if (x_valid) begin
          state_d = StMac;
        end
      end
      StMac: begin
        if (cnt_q == LastTap) begin
          cnt_d   = 6'd0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StFlush: state_d = StOut;
      StOut: begin
        if (y_ready) begin
          state_d = StWaitX;
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge ALU_restn) begin
    if (!ALU_restn) begin
      state_q <= StLoad;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    coef_ready = (state_q == StLoad);
    // Gated by reset so no write strobe escapes while the block is held in reset.
    coef_we    = coef_hs && ALU_restn;
    coef_addr  = (state_q == StLoad) ? cnt_q : 6'd0;
    x_ready    = (state_q == StWaitX);
    x_shift    = x_hs;
    acc_en     = (state_q == StMac) || (state_q == StFlush);
    acc_clr    = (state_q == StMac) && (cnt_q == 6'd0);
    y_valid    = (state_q == StOut);
    busy       = (state_q != StWaitX);
    tap_addr   = 6'd0;
    if (state_q == StMac) begin
      tap_addr = cnt_q;
    end else if (state_q == StFlush) begin
      tap_addr = LastTap;
    end
  end

endmodule
